// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_BAUD     = 9600;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

   function automatic int calc_bit_cnt(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchronizer, frame FSM, bit timing and LSB-first shifter.
import uart_pkg::*;

module uart_rx_core #(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_uart,
   output logic [7:0] rx_data,
   output logic       rx_valid
);

   localparam int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD);
   localparam int HALF_CNT = BIT_CNT / 2;
   localparam int CNT_W    = $clog2(BIT_CNT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

   logic             r_sync1, r_sync2, r_edge;
   rx_state_e        r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_valid;
   logic             w_fall, w_tick;

   assign w_fall = r_edge & ~r_sync2;

   // w_tick marks the sample point of the current bit (mid-bit).
   always_comb begin
      w_next = r_state;
      w_tick = 1'b0;
      case (r_state)
         IDLE:  if (w_fall) w_next = START;
         START: begin
            w_tick = (r_cnt == HALF_LAST);
            if (w_tick) w_next = r_sync2 ? IDLE : DATA;
         end
         DATA: begin
            w_tick = (r_cnt == BIT_LAST);
            if (w_tick && r_bit_idx == 3'd7) w_next = STOP;
         end
         STOP: begin
            w_tick = (r_cnt == BIT_LAST);
            if (w_tick) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_edge    <= 1'b1;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_sync1 <= rx_uart;
         r_sync2 <= r_sync1;
         r_edge  <= r_sync2;
         r_valid <= 1'b0;
         if (r_state == IDLE || w_tick) r_cnt <= '0;
         else                           r_cnt <= r_cnt + CNT_W'(1);
         if (r_state == IDLE) r_bit_idx <= '0;
         if (r_state == DATA && w_tick) begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
         end
         // A low stop bit is a framing error: the byte is simply never flagged.
         if (r_state == STOP && w_tick) r_valid <= r_sync2;
      end
   end

   assign rx_data  = r_shift;
   assign rx_valid = r_valid;

endmodule

// File: rtl/uart_rx_led.sv
// Board-level debug block: the low two bits of each good UART byte drive the LEDs.
import uart_pkg::*;

module uart_rx_led #(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_uart,
   output logic [1:0] led
);

   logic [7:0] w_rx_data;
   logic       w_rx_valid;
   logic       w_unused_hi;

   uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_uart  (rx_uart),
      .rx_data  (w_rx_data),
      .rx_valid (w_rx_valid)
   );

   assign w_unused_hi = ^w_rx_data[7:2];

   always_ff @(posedge clk) begin
      if (!rst_n)          led <= 2'b00;
      else if (w_rx_valid) led <= w_rx_data[1:0];
   end

endmodule

// File: tb/tb_uart_rx_led.sv
// Scoreboard bench for uart_rx_led at a scaled-down bit rate (50 clocks per bit).
module tb_uart_rx_led;

   localparam int CLK_FREQ = 5_000_000;
   localparam int BAUD     = 100_000;
   localparam int BT       = CLK_FREQ / BAUD;       // 50
   localparam int HALF     = BT / 2;                // 25
   localparam int LAT      = 3 + HALF + 9 * BT + 1; // start edge to led update

   typedef struct {
      logic [1:0] led;
      int         t0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_uart = 1'b1;
   logic [1:0] led;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   uart_rx_led #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_uart (rx_uart),
      .led     (led)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int bt,
                             input bit push);
      exp_t e;
      @(negedge clk);
      rx_uart = 1'b0;
      e.led = d[1:0];
      e.t0  = cyc;
      if (push && stop) exp_q.push_back(e);
      repeat (bt) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_uart = d[i];
         repeat (bt) @(negedge clk);
      end
      rx_uart = stop;
      repeat (bt - 1) @(negedge clk);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
      repeat (5) @(negedge clk);
   endtask

   // Monitor: every core valid pulse must match the next queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (dut.w_rx_valid) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("led_value", int'(led), int'(e.led));
               checks++;
               if (cyc - e.t0 < LAT - 2 || cyc - e.t0 > LAT + 2) begin
                  errors++;
                  $display("FAIL latency: got %0d expected %0d", cyc - e.t0, LAT);
               end
            end
         end
      end
   end

   initial begin
      repeat (50_000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      // Reset and long idle
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_led", int'(led), 0);
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (led !== 2'b00) bad++;
      end
      chk("idle_led_hold", bad, 0);

      // Valid bytes
      send_frame(8'h03, 1'b1, BT, 1'b1);
      wait_drain("b03");
      chk("led_after_03", int'(led), 3);
      send_frame(8'h02, 1'b1, BT, 1'b1);
      wait_drain("b02");

      // Upper bits ignored, with +/-2% sender rate
      send_frame(8'hA5, 1'b1, BT + 1, 1'b1);
      wait_drain("bA5");
      send_frame(8'hFC, 1'b1, BT - 1, 1'b1);
      wait_drain("bFC");

      // Back-to-back
      send_frame(8'h55, 1'b1, BT, 1'b1);
      send_frame(8'h56, 1'b1, BT, 1'b1);
      wait_drain("b55_56");
      chk("led_after_b2b", int'(led), 2);

      // Glitch shorter than half a bit
      @(negedge clk);
      rx_uart = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      rx_uart = 1'b1;
      repeat (12 * BT) @(negedge clk);
      chk("glitch_led_hold", int'(led), 2);
      send_frame(8'h01, 1'b1, BT, 1'b1);
      wait_drain("b01");

      // Framing error
      send_frame(8'h03, 1'b0, BT, 1'b1);
      @(negedge clk);
      rx_uart = 1'b1;
      repeat (3 * BT) @(negedge clk);
      chk("framing_led_hold", int'(led), 1);
      send_frame(8'h02, 1'b1, BT, 1'b1);
      wait_drain("b02_after_ferr");

      // Reset during data bit 4, released mid stop bit
      fork
         send_frame(8'h03, 1'b1, BT, 1'b0);
         begin
            repeat (5 * BT + HALF) @(negedge clk);
            rst_n = 1'b0;
            repeat (4 * BT) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      @(negedge clk);
      chk("midframe_reset_led", int'(led), 0);
      repeat (12 * BT) @(negedge clk);
      chk("midframe_no_update", int'(led), 0);
      send_frame(8'h01, 1'b1, BT, 1'b1);
      wait_drain("b01_after_rst");
      chk("final_led", int'(led), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
